fifo_rd_adapter: RTL and testbench

- Read-side consumer for the team's FIFOs. Drives the FIFO read port (rd_en / empty / registered rdata) and presents the words as a valid/ready stream to downstream logic.
- Prefetches into a 2-entry skid buffer. Sustains one word per cycle with no bubbles.
- Never issues a read while the FIFO reports empty, so FIFO read errors indicate a fault elsewhere.
- Sits in the read-clock domain, one instance per FIFO.

---
 rtl/fifo_rd_adapter.sv | 122 ++++++++++++
 tb/tb_fifo_rd_adapter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter
// ---------------
// Read-side consumer for a FIFO with a registered read port. It turns the
// FIFO read port into a valid/ready stream. A 2-entry skid buffer plus one
// tracked in-flight read lets the stream move one word per cycle with no
// bubbles. A read is never requested while the FIFO reports empty.
//
// Optional feature: define FIFO_RD_ADAPTER_CNT_EN to build a counter of
// accepted stream words on word_cnt_o. When it is not defined, word_cnt_o
// is tied to zero.
//
// Ports:
//   clk_i           read-side clock
//   rst_i           synchronous active-high reset
//   en_i            drain enable. Low stops new FIFO reads.
//   fifo_empty_i    FIFO empty flag
//   fifo_rd_en_o    FIFO read request (combinational)
//   fifo_rdata_i    FIFO read data, valid the cycle after a read is sampled
//   fifo_rd_error_i FIFO read-error flag
//   m_valid_o       stream word valid
//   m_ready_i       stream sink ready
//   m_data_o        stream word (head of the skid buffer)
//   err_o           sticky error flag, cleared only by reset
//   word_cnt_o      accepted-word count (optional feature)
module fifo_rd_adapter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  input  logic                 fifo_rd_error_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             inflight_reg;
  logic [WIDTH-1:0] buf_reg  [2];
  logic [WIDTH-1:0] buf_next [2];
  logic             err_reg;
  logic             pop;
  logic             rd_en;
  logic             wr_slot;

  always_comb begin
    pop = (count_reg != 2'd0) && m_ready_i;
    // Occupancy after this cycle. Because count + inflight <= 2, the sum
    // fits in 2 bits. pop implies count >= 1, so the subtraction cannot
    // underflow.
    count_next = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    // Issuing a read whenever the post-cycle occupancy leaves room keeps
    // one word per cycle flowing. The dependence on m_ready_i is deliberate.
    rd_en = en_i && !rst_i && !fifo_empty_i && (count_next < 2'd2);
    // Landing slot for the returning word, indexed after any shift.
    // When pop is set, the word goes to slot count-1 (count is 1 or 2).
    // Otherwise it goes to slot count (count is 0 or 1).
    wr_slot = pop ? count_reg[1] : count_reg[0];

    for (int i = 0; i < 2; i++) begin
      buf_next[i] = buf_reg[i];
    end
    if (pop) begin
      buf_next[0] = buf_reg[1];
    end
    if (inflight_reg) begin
      buf_next[wr_slot] = fifo_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      buf_reg[0]   <= '0;
      buf_reg[1]   <= '0;
      err_reg      <= 1'b0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= rd_en;
      buf_reg[0]   <= buf_next[0];
      buf_reg[1]   <= buf_next[1];
      err_reg      <= err_reg | fifo_rd_error_i;
    end
  end

  // The read-issue rule guarantees that the buffer can never overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((3'(count_reg) + 3'(inflight_reg)) <= 3'd2);
    end
  end

`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (pop) begin
      cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign word_cnt_o = cnt_reg;
`else
  assign word_cnt_o = '0;
`endif

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = (count_reg != 2'd0);
  assign m_data_o     = buf_reg[0];
  assign err_o        = err_reg;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Testbench for fifo_rd_adapter. It contains a behavioural FIFO with a
// registered read port. Each scenario task drives directed stimulus and
// compares the observed values against hand-computed expectations.
module tb_fifo_rd_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd_error;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        err;
  logic [15:0] word_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural FIFO model.
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  // Values sampled at the falling edge of the current cycle.
  logic        s_rd;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_err;
  logic [15:0] s_cnt;
  logic [7:0]  rx [$];
  int          viol = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr[11:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  fifo_rd_adapter #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .fifo_empty_i    (fifo_empty),
    .fifo_rd_en_o    (fifo_rd_en),
    .fifo_rdata_i    (fifo_rdata),
    .fifo_rd_error_i (fifo_rd_error),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_data_o        (m_data),
    .err_o           (err),
    .word_cnt_o      (word_cnt)
  );

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[11:0]] = v;
    wr_ptr++;
  endtask

  // Inputs are set 1 time unit after a rising edge. Outputs are sampled at
  // the falling edge. The task returns 1 time unit after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_err   = err;
    s_cnt   = word_cnt;
    if (s_rd && fifo_empty) viol++;
    if (s_valid && m_ready) rx.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    push(8'h5a);
    cyc();
    n_vec++;
    if (s_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", s_rd); end
    cyc();
    n_vec++;
    if (s_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    n_vec++;
    if (s_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", s_data); end
    n_vec++;
    if (s_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", s_err); end
    n_vec++;
    if (s_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", s_cnt); end
    n_vec++;
    if (s_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en2: got %b want 0", s_rd); end
    rst = 1'b0;
    rx.delete();
    repeat (5) cyc();
    n_vec++;
    if (rx.size() != 1 || rx[0] !== 8'h5a)
      begin n_bad++; $display("FAIL reset_first_word: got %0d words want 1 word 5a", rx.size()); end
  endtask

  task automatic test_stream();
    logic e;
    rx.delete();
    en = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    m_ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cyc();
      e = (k < 16);
      n_vec++;
      if (s_rd !== e) begin n_bad++; $display("FAIL stream_rd_en[%0d]: got %b want %b", k, s_rd, e); end
      e = (k >= 2 && k < 18);
      n_vec++;
      if (s_valid !== e) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want %b", k, s_valid, e); end
      if (e) begin
        n_vec++;
        if (s_data !== 8'(k - 1))
          begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", k, s_data, 8'(k - 1)); end
      end
    end
    n_vec++;
    if (s_err !== 1'b0) begin n_bad++; $display("FAIL stream_err: got %b want 0", s_err); end
  endtask

  task automatic test_backpressure();
    int nrd = 0;
    rx.delete();
    m_ready = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    for (int k = 0; k < 8; k++) begin
      cyc();
      nrd += int'(s_rd);
    end
    n_vec++;
    if (nrd != 2) begin n_bad++; $display("FAIL bp_reads: got %0d want 2", nrd); end
    n_vec++;
    if (s_rd !== 1'b0) begin n_bad++; $display("FAIL bp_rd_idle: got %b want 0", s_rd); end
    n_vec++;
    if (s_valid !== 1'b1 || s_data !== 8'h01)
      begin n_bad++; $display("FAIL bp_hold: got valid %b data %h want 1 01", s_valid, s_data); end
    m_ready = 1'b1;
    repeat (8) cyc();
    n_vec++;
    if (rx.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", rx.size()); end
    for (int i = 0; i < rx.size() && i < 4; i++) begin
      n_vec++;
      if (rx[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] v;
    logic [7:0] pd;
    logic       pv;
    logic       pr;
    int         pushed = 0;
    int         budget = 0;
    logic [15:0] exp_cnt;
    rst = 1'b1; cyc(); rst = 1'b0;
    rx.delete(); viol = 0;
    en = 1'b1; pv = 1'b0; pr = 1'b0; pd = 8'h00;
    while (rx.size() < 200 && budget < 4000) begin
      if (pushed < 200 && $urandom_range(0, 1) == 1) begin
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        pushed++;
      end
      m_ready = ($urandom_range(0, 1) == 1);
      cyc();
      if (pv && !pr) begin
        n_vec++;
        if (s_valid !== 1'b1 || s_data !== pd)
          begin n_bad++; $display("FAIL rnd_stable: got valid %b data %h want 1 %h", s_valid, s_data, pd); end
      end
      pv = s_valid; pr = m_ready; pd = s_data;
      budget++;
    end
    m_ready = 1'b0;
    cyc();
    n_vec++;
    if (rx.size() != 200) begin n_bad++; $display("FAIL rnd_count: got %0d want 200", rx.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (rx[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rx[i], exp_q[i]); end
    end
    n_vec++;
    if (viol != 0) begin n_bad++; $display("FAIL rnd_rd_while_empty: got %0d want 0", viol); end
`ifdef FIFO_RD_ADAPTER_CNT_EN
    exp_cnt = 16'd200;
`else
    exp_cnt = 16'd0;
`endif
    n_vec++;
    if (s_cnt !== exp_cnt) begin n_bad++; $display("FAIL rnd_word_cnt: got %0d want %0d", s_cnt, exp_cnt); end
  endtask

  task automatic test_error();
    rx.delete();
    en = 1'b1; m_ready = 1'b1; fifo_rd_error = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hc0 + 8'(i));
    cyc();
    n_vec++;
    if (s_err !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b want 0", s_err); end
    fifo_rd_error = 1'b1;
    cyc();
    n_vec++;
    if (s_err !== 1'b0) begin n_bad++; $display("FAIL err_same_cycle: got %b want 0", s_err); end
    fifo_rd_error = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_vec++;
      if (s_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky[%0d]: got %b want 1", k, s_err); end
    end
    n_vec++;
    if (rx.size() != 6) begin n_bad++; $display("FAIL err_count: got %0d want 6", rx.size()); end
    for (int i = 0; i < rx.size() && i < 6; i++) begin
      n_vec++;
      if (rx[i] !== 8'hc0 + 8'(i))
        begin n_bad++; $display("FAIL err_data[%0d]: got %h want %h", i, rx[i], 8'hc0 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    rx.delete();
    for (int i = 0; i < 6; i++) push(8'hb0 + 8'(i));
    m_ready = 1'b0; en = 1'b1;
    cyc();
    cyc();
    n_vec++;
    if (s_rd !== 1'b1) begin n_bad++; $display("FAIL rmid_second_read: got %b want 1", s_rd); end
    rst = 1'b1;
    cyc();
    n_vec++;
    if (s_rd !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_in_reset: got %b want 0", s_rd); end
    rst = 1'b0;
    cyc();
    n_vec++;
    if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", s_valid); end
    n_vec++;
    if (s_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b want 0", s_err); end
    n_vec++;
    if (s_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 0", s_cnt); end
    m_ready = 1'b1;
    repeat (10) cyc();
    n_vec++;
    if (rx.size() != 4) begin n_bad++; $display("FAIL rmid_count: got %0d want 4", rx.size()); end
    for (int i = 0; i < rx.size() && i < 4; i++) begin
      n_vec++;
      if (rx[i] !== 8'hb2 + 8'(i))
        begin n_bad++; $display("FAIL rmid_data[%0d]: got %h want %h", i, rx[i], 8'hb2 + 8'(i)); end
    end
  endtask

  task automatic test_en_drop();
    int nrd = 0;
    rx.delete();
    for (int i = 1; i <= 4; i++) push(8'ha0 + 8'(i));
    m_ready = 1'b1; en = 1'b1;
    cyc();
    n_vec++;
    if (s_rd !== 1'b1) begin n_bad++; $display("FAIL endrop_issue: got %b want 1", s_rd); end
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      nrd += int'(s_rd);
    end
    n_vec++;
    if (nrd != 0) begin n_bad++; $display("FAIL endrop_reads: got %0d want 0", nrd); end
    n_vec++;
    if (rx.size() != 1 || rx[0] !== 8'ha1)
      begin n_bad++; $display("FAIL endrop_inflight: got %0d words want 1 word a1", rx.size()); end
    en = 1'b1;
    repeat (10) cyc();
    n_vec++;
    if (rx.size() != 4) begin n_bad++; $display("FAIL endrop_count: got %0d want 4", rx.size()); end
    for (int i = 1; i < rx.size() && i < 4; i++) begin
      n_vec++;
      if (rx[i] !== 8'ha1 + 8'(i))
        begin n_bad++; $display("FAIL endrop_data[%0d]: got %h want %h", i, rx[i], 8'ha1 + 8'(i)); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_rd_error = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_error();
    test_reset_mid();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
